lfsr_seq_checker: RTL and testbench
===================================

// Module: lfsr_seq_checker
// PURPOSE
//  Receive-side partner of the 13-bit LFSR generator. Samples the generator's parallel word
//  (rnd) and self-synchronises to its sequence. Flags and counts words that break the sequence.
//  Sits between the random source and the hit/miss logic, as a health monitor of the randomizer.
// PARAMETERS
//  WIDTH     13       LFSR word width
//  TAPS      13'h100D feedback mask; fb = ^(w & TAPS), i.e. bits 12,3,2,0
//  LOCK_CNT  4        consecutive correct predictions needed to lock (>=1)
//  LOSS_CNT  3        consecutive mispredictions in LOCKED that drop lock (>=1)
//  CNT_W     16       err_count width
// PORTS
//  clock      in   1      single clock, rising edge
//  reset      in   1      asynchronous, active-low reset
//  rnd_valid  in   1      rnd holds a new generator word (generator stepped once)
//  rnd        in   WIDTH  generator word
//  clear      in   1      sync clear of err_count and lock_lost
//  locked     out  1      checker is in LOCKED
//  err_pulse  out  1      one-cycle pulse: LOCKED sample mispredicted
//  err_count  out  CNT_W  saturating count of LOCKED mispredictions
//  lock_lost  out  1      sticky: LOCKED->SEARCH occurred since reset/clear
// BEHAVIOUR
//  - Step function: next(w) = {w[WIDTH-2:0], ^(w & TAPS)}. Example: 1FFF->1FFE->1FFD.
//  - Reset (reset==0, async): state=SEARCH; have_prev=0; run=0; miss=0; all outputs 0.
//  - Cycles with rnd_valid=0: no state, counter or prediction change; err_pulse=0.
//  - First valid word after reset or lock loss: seeds exp=next(rnd) and sets have_prev.
//    No compare is made on that word.
//  - SEARCH, valid word: match = (rnd==exp).
//    Match: run++. Mismatch: run=0.
//    In both cases exp reseeds from the received word: exp=next(rnd).
//    When run reaches LOCK_CNT -> LOCKED, run=0, miss=0.
//  - LOCKED, valid word: exp advances from the local copy only: exp=next(exp), never from rnd.
//    Match: miss=0.
//    Mismatch: err_pulse=1, err_count+=1 (saturates at all-ones), miss++.
//    When miss reaches LOSS_CNT -> SEARCH, lock_lost=1, have_prev=0, run=0.
//  - Latency: locked, err_pulse, err_count and lock_lost are registered.
//    They update on the edge that samples the word, so they are visible the next cycle.
//  - clear: takes priority over a same-cycle error. err_count=0 and lock_lost=0.
//    err_pulse still fires. State and predictor are unaffected.
//  - The lock-dropping mismatch counts as an error. locked falls in the same cycle err_pulse=1.
//  - Reset asserted mid-run returns the block to SEARCH immediately. No partial state survives.
// CONFIGURATION
//  LFSR_CHK_LOCKUP_DET_EN defined:
//    - Adds output port stuck_zero (1 bit, reset 0).
//    - stuck_zero is registered, 1 while the last valid word was all-zero.
//    - In SEARCH an all-zero word never counts as a match, and run=0.
//    - In LOCKED an all-zero word is a mismatch.
//  Not defined:
//    - Port absent.
//    - All-zero words are treated like any other word; a stuck-zero generator can therefore lock.
// STRUCTURE
//  - Package lfsr_chk_pkg holds:
//      state enum {SEARCH, LOCKED}
//      default WIDTH and TAPS constants
//      function lfsr_next(w, taps)
//  - One combinational sub-module lfsr_step (word -> next word).
//    It is instantiated twice: reseed path from rnd, and local path from exp.
//  - Everything else stays in this module: FSM, run/miss counters, error counter.
// TESTING
//  1 Reset: hold reset=0, drive rnd=1FFF valid.
//    -> all outputs 0; after release first word seeds, locked=0.
//  2 Lock: feed 1FFF,1FFE,1FFD,... valid every cycle.
//    -> locked=1 the cycle after the 5th word (1 seed + 4 matches); err_count=0.
//  3 Single error while locked: replace one word with 0x0ABC.
//    -> one err_pulse, err_count=1, locked stays 1.
//    -> the following correct words match with no further errors.
//  4 Loss: 3 consecutive corrupted words.
//    -> err_count=3, locked=0 and lock_lost=1 after the 3rd.
//    -> correct words then re-lock after 1+4 words.
//  5 Gaps: correct sequence with rnd_valid toggling 1,0,0,1.
//    -> no errors; lock timing counts only valid words.
//  6 clear with an error on the same cycle -> err_count=0, err_pulse=1.
//    With LOCKUP_DET: feed all-zero words -> stuck_zero=1, locked stays 0.

Source files
------------

// File: rtl/lfsr_chk_pkg.sv
// Shared types and constants for the 13-bit LFSR sequence checker.
// The lfsr_next helper describes the generator's step function for the default word width.
package lfsr_chk_pkg;

    localparam int unsigned       LFSR_W    = 13;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 13'h100D;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } chk_state_t;

    // Shift left, feed back the parity of the tapped bits into bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] w,
                                                    input logic [LFSR_W-1:0] taps);
        return {w[LFSR_W-2:0], ^(w & taps)};
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational single step of the Fibonacci LFSR: word -> next word.
module lfsr_step
    import lfsr_chk_pkg::*;
#(
    parameter int unsigned      WIDTH = LFSR_W,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS)
) (
    input  logic [WIDTH-1:0] word,
    output logic [WIDTH-1:0] next_word_c
);

    assign next_word_c = {word[WIDTH-2:0], ^(word & TAPS)};

endmodule

// File: rtl/lfsr_seq_checker.sv
// Receive-side LFSR sequence checker: self-synchronises to the generator and counts breaks.
// Optional all-zero lockup detection (stuck_zero port) is enabled by LFSR_CHK_LOCKUP_DET_EN.
module lfsr_seq_checker
    import lfsr_chk_pkg::*;
#(
    parameter int unsigned      WIDTH    = LFSR_W,
    parameter logic [WIDTH-1:0] TAPS     = WIDTH'(LFSR_TAPS),
    parameter int unsigned      LOCK_CNT = 4,
    parameter int unsigned      LOSS_CNT = 3,
    parameter int unsigned      CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rnd_valid,
    input  logic [WIDTH-1:0] rnd,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic             lock_lost
`ifdef LFSR_CHK_LOCKUP_DET_EN
    ,
    output logic             stuck_zero
`endif
);

    localparam int unsigned RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int unsigned MISS_W = $clog2(LOSS_CNT + 1);

    chk_state_t        state_q, state_d;
    logic              have_prev_q, have_prev_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic [WIDTH-1:0]  exp_q, exp_d;
    logic              err_pulse_d;
    logic [CNT_W-1:0]  err_count_d;
    logic              lock_lost_d;

    logic [WIDTH-1:0]  rnd_next;
    logic [WIDTH-1:0]  exp_next;
    logic              zero_word;
    logic              rnd_match;

    // Reseed path follows the received word; local path free-runs from the prediction.
    lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS)) u_step_rnd (
        .word        (rnd),
        .next_word_c (rnd_next)
    );

    lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS)) u_step_exp (
        .word        (exp_q),
        .next_word_c (exp_next)
    );

`ifdef LFSR_CHK_LOCKUP_DET_EN
    assign zero_word = (rnd == '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stuck_zero <= 1'b0;
        end else if (rnd_valid) begin
            stuck_zero <= zero_word;
        end
    end
`else
    assign zero_word = 1'b0;
`endif

    // An all-zero word can never be a legitimate prediction hit when lockup detection is on.
    assign rnd_match = (rnd == exp_q) && !zero_word;
    assign locked    = (state_q == LOCKED);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= SEARCH;
            have_prev_q <= 1'b0;
            run_q       <= '0;
            miss_q      <= '0;
            exp_q       <= '0;
            err_pulse   <= 1'b0;
            err_count   <= '0;
            lock_lost   <= 1'b0;
        end else begin
            state_q     <= state_d;
            have_prev_q <= have_prev_d;
            run_q       <= run_d;
            miss_q      <= miss_d;
            exp_q       <= exp_d;
            err_pulse   <= err_pulse_d;
            err_count   <= err_count_d;
            lock_lost   <= lock_lost_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        have_prev_d = have_prev_q;
        run_d       = run_q;
        miss_d      = miss_q;
        exp_d       = exp_q;
        err_pulse_d = 1'b0;
        err_count_d = err_count;
        lock_lost_d = lock_lost;

        if (rnd_valid) begin
            if (!have_prev_q) begin
                exp_d       = rnd_next;
                have_prev_d = 1'b1;
            end else if (state_q == SEARCH) begin
                exp_d = rnd_next;
                if (!rnd_match) begin
                    run_d = '0;
                end else if (run_q == RUN_W'(LOCK_CNT - 1)) begin
                    state_d = LOCKED;
                    run_d   = '0;
                    miss_d  = '0;
                end else begin
                    run_d = run_q + RUN_W'(1);
                end
            end else begin
                exp_d = exp_next;
                if (rnd_match) begin
                    miss_d = '0;
                end else begin
                    err_pulse_d = 1'b1;
                    if (err_count != '1) begin
                        err_count_d = err_count + CNT_W'(1);
                    end
                    // The lock-dropping miss still counts as an error above.
                    if (miss_q == MISS_W'(LOSS_CNT - 1)) begin
                        state_d     = SEARCH;
                        lock_lost_d = 1'b1;
                        have_prev_d = 1'b0;
                        run_d       = '0;
                        miss_d      = '0;
                    end else begin
                        miss_d = miss_q + MISS_W'(1);
                    end
                end
            end
        end

        if (clear) begin
            err_count_d = '0;
            lock_lost_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Directed self-checking bench for lfsr_seq_checker (default build, lockup detection off).
module tb_lfsr_seq_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [12:0] rnd = '0;
    logic        clear = 1'b0;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic        lock_lost;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;
    logic [12:0] gw;

    lfsr_seq_checker dut (
        .clock     (clk),
        .reset     (rst_n),
        .rnd_valid (valid),
        .rnd       (rnd),
        .clear     (clear),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .lock_lost (lock_lost)
    );

    always #5 clk = ~clk;

    // Generator step written from the tap list: new bit = w12 ^ w3 ^ w2 ^ w0.
    function automatic logic [12:0] nxt(input logic [12:0] w);
        logic fb;
        fb = w[12] ^ w[3] ^ w[2] ^ w[0];
        return (13'((w << 1)) | 13'(fb));
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of what the checker must report.
    bit          m_have = 0;
    bit          m_locked = 0;
    logic [12:0] m_exp = '0;
    int          m_run = 0;
    int          m_miss = 0;
    bit          m_pulse = 0;
    int          m_cnt = 0;
    bit          m_lost = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_have = 0; m_locked = 0; m_exp = '0; m_run = 0; m_miss = 0;
            m_pulse = 0; m_cnt = 0; m_lost = 0;
        end else begin
            m_pulse = 0;
            if (valid) begin
                if (!m_have) begin
                    m_exp = nxt(rnd);
                    m_have = 1;
                end else if (!m_locked) begin
                    m_run = (rnd == m_exp) ? m_run + 1 : 0;
                    m_exp = nxt(rnd);
                    if (m_run == 4) begin
                        m_locked = 1; m_run = 0; m_miss = 0;
                    end
                end else begin
                    if (rnd == m_exp) begin
                        m_miss = 0;
                    end else begin
                        m_pulse = 1;
                        if (m_cnt < 65535) m_cnt = m_cnt + 1;
                        m_miss = m_miss + 1;
                        if (m_miss == 3) begin
                            m_locked = 0; m_lost = 1; m_have = 0; m_run = 0; m_miss = 0;
                        end
                    end
                    m_exp = nxt(m_exp);
                end
            end
            if (clear) begin
                m_cnt = 0;
                m_lost = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("locked", int'(locked), int'(m_locked));
            check("err_pulse", int'(err_pulse), int'(m_pulse));
            check("err_count", int'(err_count), m_cnt);
            check("lock_lost", int'(lock_lost), int'(m_lost));
        end
    end

    task automatic send(input logic v, input logic [12:0] w, input logic c);
        valid = v;
        rnd   = w;
        clear = c;
        @(negedge clk);
    endtask

    task automatic good();
        send(1'b1, gw, 1'b0);
        gw = nxt(gw);
    endtask

    task automatic bad(input logic [12:0] flip, input logic c);
        send(1'b1, gw ^ flip, c);
        gw = nxt(gw);
    endtask

    initial begin
        gw = 13'h1FFF;
        check("nxt_1fff", int'(nxt(13'h1FFF)), 'h1FFE);
        check("nxt_1ffe", int'(nxt(13'h1FFE)), 'h1FFD);

        // Reset held with a valid word present
        valid = 1'b1; rnd = 13'h1FFF;
        cmp_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_locked", int'(locked), 0);
        check("rst_count", int'(err_count), 0);
        rst_n = 1'b1;

        // Lock: seed plus four matches
        repeat (4) good();
        check("pre_lock", int'(locked), 0);
        good();
        check("lock", int'(locked), 1);
        check("lock_count", int'(err_count), 0);

        // Single error while locked
        repeat (2) good();
        bad(13'h0ABC, 1'b0);
        check("single_pulse", int'(err_pulse), 1);
        check("single_count", int'(err_count), 1);
        check("single_locked", int'(locked), 1);
        good();
        check("single_after", int'(err_pulse), 0);
        repeat (3) good();
        check("single_hold", int'(err_count), 1);

        // Clear, then three consecutive errors drop lock
        send(1'b0, 13'h0000, 1'b1);
        check("clr_count", int'(err_count), 0);
        bad(13'h0001, 1'b0);
        bad(13'h0002, 1'b0);
        check("loss_2_locked", int'(locked), 1);
        bad(13'h0ABC, 1'b0);
        check("loss_locked", int'(locked), 0);
        check("loss_pulse", int'(err_pulse), 1);
        check("loss_count", int'(err_count), 3);
        check("loss_sticky", int'(lock_lost), 1);
        repeat (4) good();
        check("relock_pre", int'(locked), 0);
        good();
        check("relock", int'(locked), 1);

        // Mid-run reset returns everything to idle
        valid = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_locked", int'(locked), 0);
        check("mid_rst_lost", int'(lock_lost), 0);
        check("mid_rst_count", int'(err_count), 0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Gapped valid stream: only valid words count toward lock
        for (int i = 0; i < 5; i++) begin
            good();
            if (i == 3) check("gap_pre_lock", int'(locked), 0);
            if (i < 4) begin
                send(1'b0, 13'h1234, 1'b0);
                send(1'b0, 13'h0000, 1'b0);
            end
        end
        check("gap_lock", int'(locked), 1);
        check("gap_count", int'(err_count), 0);

        // clear wins over a same-cycle error, but the pulse still fires
        bad(13'h0001, 1'b0);
        check("pre_clr_count", int'(err_count), 1);
        bad(13'h0ABC, 1'b1);
        check("clr_err_pulse", int'(err_pulse), 1);
        check("clr_err_count", int'(err_count), 0);
        check("clr_err_locked", int'(locked), 1);
        good();
        check("post_clr_count", int'(err_count), 0);
        check("post_clr_locked", int'(locked), 1);

        send(1'b0, 13'h0000, 1'b0);
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
